// File: rtl/qos_mm_regs.sv
// QoS channel-selector register block: config, status, and per-channel error
// counters with W1C and periodic auto-clear; 1-cycle registered read path.
module qos_errcnt_lane (
  input  logic       rclk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] cnt
);
  // a clear wins over a coincident increment; the event is dropped
  always_ff @(posedge rclk) begin
    if (rst)                        cnt <= '0;
    else if (clr)                   cnt <= '0;
    else if (inc && cnt != 8'hFF)   cnt <= cnt + 8'd1;
  end
endmodule

module qos_mm_regs #(
  parameter int NUM_CH = 4
) (
  input  logic               rclk,
  input  logic               rst,
  input  logic               mm_write_en,
  input  logic               mm_read_en,
  input  logic [7:0]         mm_addr,
  input  logic [31:0]        mm_wdata,
  output logic [31:0]        mm_rdata,
  output logic               fallback_enable,
  output logic               manual_enable,
  output logic [1:0]         manual_channel,
  output logic [7:0]         channel_priority,
  output logic [19:0]        reset_timer,
  input  logic [1:0]         active_channel,
  input  logic [NUM_CH-1:0]  signal_present,
  input  logic [NUM_CH-1:0]  error_pulse
);
  localparam logic [7:0]  A_CONFIG = 8'h00;
  localparam logic [7:0]  A_STATUS = 8'h01;
  localparam logic [7:0]  A_ERRCNT = 8'h02;
  localparam logic [7:0]  A_ID     = 8'h03;
  localparam logic [31:0] ID_VAL   = 32'h5153_0001;

  logic                   wr_cfg, wr_err, rd_status;
  logic [3:0]             prio_seen;
  logic                   prio_ok;
  logic                   prio_err;
  logic [19:0]            tmr;
  logic                   tmr_hit;
  logic [NUM_CH-1:0]      cnt_clr;
  logic [NUM_CH-1:0][7:0] cnt;
  logic [31:0]            rd_val;

  assign wr_cfg    = mm_write_en && (mm_addr == A_CONFIG);
  assign wr_err    = mm_write_en && (mm_addr == A_ERRCNT);
  assign rd_status = mm_read_en  && (mm_addr == A_STATUS);

  // priority field is legal only if its four 2-bit entries cover 0..3
  always_comb begin
    prio_seen = '0;
    for (int i = 0; i < 4; i++) prio_seen[mm_wdata[4+2*i +: 2]] = 1'b1;
  end
  assign prio_ok = &prio_seen;

  always_ff @(posedge rclk) begin
    if (rst) begin
      fallback_enable  <= 1'b1;
      manual_enable    <= 1'b0;
      manual_channel   <= 2'd0;
      channel_priority <= 8'hE4;
      reset_timer      <= '0;
    end else if (wr_cfg) begin
      fallback_enable <= mm_wdata[0];
      manual_enable   <= mm_wdata[1];
      manual_channel  <= mm_wdata[3:2];
      reset_timer     <= mm_wdata[31:12];
      if (prio_ok) channel_priority <= mm_wdata[11:4];
    end
  end

  // sticky error: a new set in the read cycle survives the read-clear
  always_ff @(posedge rclk) begin
    if (rst)                      prio_err <= 1'b0;
    else if (wr_cfg && !prio_ok)  prio_err <= 1'b1;
    else if (rd_status)           prio_err <= 1'b0;
  end

  assign tmr_hit = (reset_timer != '0) && (tmr == reset_timer - 20'd1);

  always_ff @(posedge rclk) begin
    if (rst || wr_cfg || reset_timer == '0 || tmr_hit) tmr <= '0;
    else                                               tmr <= tmr + 20'd1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign cnt_clr[g] = tmr_hit || (wr_err && mm_wdata[g]);
    qos_errcnt_lane u_lane (
      .rclk (rclk),
      .rst  (rst),
      .clr  (cnt_clr[g]),
      .inc  (error_pulse[g]),
      .cnt  (cnt[g])
    );
  end

  always_comb begin
    rd_val = '0;
    case (mm_addr)
      A_CONFIG: rd_val = {reset_timer, channel_priority, manual_channel,
                          manual_enable, fallback_enable};
      A_STATUS: rd_val = {25'b0, prio_err, signal_present, active_channel};
      A_ERRCNT: rd_val = cnt;
      A_ID:     rd_val = ID_VAL;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (rst)             mm_rdata <= '0;
    else if (mm_read_en) mm_rdata <= rd_val;
  end
endmodule

// File: tb/tb_qos_mm_regs.sv
// Directed bench for qos_mm_regs; read results go through an expected-value queue.
module tb_qos_mm_regs;
  logic        rclk = 1'b0;
  logic        rst;
  logic        mm_write_en, mm_read_en;
  logic [7:0]  mm_addr;
  logic [31:0] mm_wdata, mm_rdata;
  logic        fallback_enable, manual_enable;
  logic [1:0]  manual_channel, active_channel;
  logic [7:0]  channel_priority;
  logic [19:0] reset_timer;
  logic [3:0]  signal_present, error_pulse;

  int checks = 0;
  int failures = 0;
  logic [31:0] sb_q[$];
  string       tag_q[$];

  always #5 rclk = ~rclk;

  qos_mm_regs dut (
    .rclk             (rclk),
    .rst              (rst),
    .mm_write_en      (mm_write_en),
    .mm_read_en       (mm_read_en),
    .mm_addr          (mm_addr),
    .mm_wdata         (mm_wdata),
    .mm_rdata         (mm_rdata),
    .fallback_enable  (fallback_enable),
    .manual_enable    (manual_enable),
    .manual_channel   (manual_channel),
    .channel_priority (channel_priority),
    .reset_timer      (reset_timer),
    .active_channel   (active_channel),
    .signal_present   (signal_present),
    .error_pulse      (error_pulse)
  );

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk();
    logic [31:0] e;
    string t;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      chk(t, mm_rdata, e);
    end
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
    mm_read_en = 1'b1;
    mm_addr    = a;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    tick();
    mm_read_en = 1'b0;
    pop_chk();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    mm_write_en = 1'b1;
    mm_addr     = a;
    mm_wdata    = d;
    tick();
    mm_write_en = 1'b0;
  endtask

  task automatic chk_cfg(input string tag, input logic fb, input logic me,
                         input logic [1:0] mc, input logic [7:0] pr, input logic [19:0] rt);
    chk({tag, "_fb"}, 32'(fallback_enable), 32'(fb));
    chk({tag, "_me"}, 32'(manual_enable), 32'(me));
    chk({tag, "_mc"}, 32'(manual_channel), 32'(mc));
    chk({tag, "_prio"}, 32'(channel_priority), 32'(pr));
    chk({tag, "_rt"}, 32'(reset_timer), 32'(rt));
  endtask

  initial begin
    rst = 1'b1;
    mm_write_en = 1'b0; mm_read_en = 1'b0;
    mm_addr = '0; mm_wdata = '0;
    active_channel = 2'd2; signal_present = 4'hA; error_pulse = 4'h0;
    tick();
    // write attempted while in reset must not land
    mm_write_en = 1'b1; mm_addr = 8'h00; mm_wdata = 32'hFFFF_FFF0;
    tick();
    mm_write_en = 1'b0;
    chk("rst_rdata", mm_rdata, 32'h0);
    chk_cfg("rst", 1'b1, 1'b0, 2'd0, 8'hE4, 20'h0);
    rst = 1'b0;

    rd(8'h00, 32'h0000_0E41, "cfg_reset_read");
    rd(8'h03, 32'h5153_0001, "id_read");
    rd(8'h02, 32'h0, "errcnt_reset");
    rd(8'h01, 32'h0000_002A, "status_reset");

    wr(8'h00, 32'hB71B_0D29);
    chk_cfg("cfg_wr", 1'b1, 1'b0, 2'd2, 8'hD2, 20'hB71B0);
    rd(8'h00, 32'hB71B_0D29, "cfg_readback");

    // illegal priority: others update, priority kept, sticky error once
    wr(8'h00, 32'h0000_000E);
    chk_cfg("bad_prio", 1'b0, 1'b1, 2'd3, 8'hD2, 20'h0);
    rd(8'h00, 32'h0000_0D2E, "bad_prio_readback");
    rd(8'h01, 32'h0000_006A, "status_prio_err_set");
    rd(8'h01, 32'h0000_002A, "status_prio_err_clr");

    error_pulse = 4'b0010;
    repeat (300) tick();
    error_pulse = 4'h0;
    rd(8'h02, 32'h0000_FF00, "cnt1_saturate");
    wr(8'h02, 32'h0000_0002);
    rd(8'h02, 32'h0, "cnt1_w1c");
    error_pulse = 4'b0010;
    repeat (3) tick();
    error_pulse = 4'h0;
    rd(8'h02, 32'h0000_0300, "cnt1_three");
    error_pulse = 4'b0010;
    wr(8'h02, 32'h0000_0002);
    error_pulse = 4'h0;
    rd(8'h02, 32'h0, "clear_beats_inc");

    // auto-clear every 10 cycles; read held high, one read per cycle
    wr(8'h02, 32'h0000_000F);
    wr(8'h00, 32'h0000_AE41);
    for (int j = 0; j < 25; j++) begin
      error_pulse = 4'b0001;
      mm_read_en  = 1'b1;
      mm_addr     = 8'h02;
      sb_q.push_back(32'(j % 10));
      tag_q.push_back($sformatf("autoclr_j%0d", j));
      tick();
      pop_chk();
    end
    error_pulse = 4'h0;
    mm_read_en  = 1'b0;
    rd(8'h02, 32'h0000_0005, "autoclr_final");

    rd(8'h55, 32'h0, "unmapped_read");
    wr(8'h03, 32'hDEAD_BEEF);
    wr(8'h55, 32'hDEAD_BEEF);
    rd(8'h03, 32'h5153_0001, "id_ro");
    rd(8'h00, 32'h0000_AE41, "cfg_unaffected");

    // simultaneous read and write returns the pre-write value
    mm_read_en = 1'b1; mm_write_en = 1'b1;
    mm_addr = 8'h00; mm_wdata = 32'h0000_0E41;
    sb_q.push_back(32'h0000_AE41);
    tag_q.push_back("rw_same_cycle");
    tick();
    mm_read_en = 1'b0; mm_write_en = 1'b0;
    pop_chk();
    repeat (3) tick();
    chk("rdata_hold", mm_rdata, 32'h0000_AE41);
    rd(8'h00, 32'h0000_0E41, "rw_write_landed");

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
